mmio_led_responder: RTL

- Memory-mapped bus responder that owns the SOC's 64-bit LED output and a free-running cycle counter.
- The CPU load/store unit is the initiator. This block answers its requests, and the LED word is what the top-level bench monitors.
- Sits inside SOC on the data-side bus, after the address decode has picked the I/O window.

---
 rtl/soc_mmio_pkg.sv | 40 ++++
 rtl/mmio_cycle_timer.sv | 40 ++++
 rtl/mmio_led_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/soc_mmio_pkg.sv
// Shared definitions for the SOC MMIO responders: register offsets,
// STATUS bit positions, bus FSM states and byte-strobe helpers.
package soc_mmio_pkg;

  localparam logic [5:0] LED_OFF     = 6'h00;
  localparam logic [5:0] LED_SET_OFF = 6'h08;
  localparam logic [5:0] LED_CLR_OFF = 6'h10;
  localparam logic [5:0] LED_TGL_OFF = 6'h18;
  localparam logic [5:0] CYCLE_OFF   = 6'h20;
  localparam logic [5:0] CMP_OFF     = 6'h28;
  localparam logic [5:0] STATUS_OFF  = 6'h30;
  localparam logic [5:0] RSVD_OFF    = 6'h38;

  localparam int unsigned STATUS_MATCH_BIT  = 0;
  localparam int unsigned STATUS_IRQ_EN_BIT = 1;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic [63:0] strb_mask(input logic [7:0] strb);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      m[i*8 +: 8] = {8{strb[i]}};
    end
    return m;
  endfunction

  // Enabled bytes take the new value, disabled bytes keep the old one.
  function automatic logic [63:0] apply_wstrb(input logic [63:0] old_val,
                                              input logic [63:0] new_val,
                                              input logic [7:0]  strb);
    logic [63:0] m;
    m = strb_mask(strb);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/mmio_cycle_timer.sv
// Free-running 64-bit cycle counter with a compare register and a sticky
// MATCH flag (hardware set beats a same-cycle software clear).
module mmio_cycle_timer
  import soc_mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        cycle_we,
  input  logic        cmp_we,
  input  logic        match_clr,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  output logic [63:0] cycle,
  output logic [63:0] cmp,
  output logic        match
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle <= '0;
      cmp   <= '1;
      match <= 1'b0;
    end else begin
      if (cycle_we) begin
        cycle <= apply_wstrb(cycle, wdata, wstrb);
      end else begin
        cycle <= cycle + 64'd1;
      end
      if (cmp_we) begin
        cmp <= apply_wstrb(cmp, wdata, wstrb);
      end
      if (cycle == cmp) begin
        match <= 1'b1;
      end else if (match_clr) begin
        match <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mmio_led_responder.sv
// Data-side MMIO responder owning the 64-bit LED register and the cycle
// timer; one request at a time through a two-state IDLE/RESP handshake.
module mmio_led_responder
  import soc_mmio_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_1000_0000,
  parameter logic [63:0] LED_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] LED,
  output logic        irq
);

  state_t      state;
  logic        irq_en;
  logic [5:0]  off;
  logic        addr_err;
  logic        accept;
  logic        wr_ok;
  logic [63:0] wbits;
  logic [63:0] rd_data;
  logic [63:0] cycle;
  logic [63:0] cmp;
  logic        match;

  assign off      = req_addr[5:0];
  assign addr_err = (req_addr[63:6] != BASE_ADDR[63:6]) || (req_addr[2:0] != 3'b000);
  assign accept   = req_valid && (state == IDLE);
  assign wr_ok    = accept && req_we && !addr_err;
  assign wbits    = req_wdata & strb_mask(req_wstrb);

  mmio_cycle_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .cycle_we  (wr_ok && (off == CYCLE_OFF)),
    .cmp_we    (wr_ok && (off == CMP_OFF)),
    .match_clr (wr_ok && (off == STATUS_OFF) && wbits[STATUS_MATCH_BIT]),
    .wdata     (req_wdata),
    .wstrb     (req_wstrb),
    .cycle     (cycle),
    .cmp       (cmp),
    .match     (match)
  );

  always_comb begin
    rd_data = '0;
    case (off)
      LED_OFF:    rd_data = LED;
      CYCLE_OFF:  rd_data = cycle;
      CMP_OFF:    rd_data = cmp;
      STATUS_OFF: begin
        rd_data[STATUS_MATCH_BIT]  = match;
        rd_data[STATUS_IRQ_EN_BIT] = irq_en;
      end
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      LED        <= LED_RESET;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      irq <= match & irq_en;
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            req_ready  <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= addr_err;
            resp_rdata <= (addr_err || req_we) ? '0 : rd_data;
            if (wr_ok) begin
              case (off)
                LED_OFF:     LED <= apply_wstrb(LED, req_wdata, req_wstrb);
                LED_SET_OFF: LED <= LED | wbits;
                LED_CLR_OFF: LED <= LED & ~wbits;
                LED_TGL_OFF: LED <= LED ^ wbits;
                STATUS_OFF:  if (req_wstrb[0]) irq_en <= req_wdata[STATUS_IRQ_EN_BIT];
                default:     ;
              endcase
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
